// File: rtl/icache_line_refill.sv
// Line refill engine: turns one L1i miss into LINE_WORDS pipelined Wishbone reads
// and returns the assembled line (or an error) with a single-cycle completion pulse.
module icache_line_refill #(
   parameter int AW         = 32,
   parameter int MW         = 64,
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_miss_req,
   input  logic [AW-1:0]            i_miss_addr,
   output logic                     o_busy,
   output logic                     o_fill_done,
   output logic                     o_fill_err,
   output logic [AW-1:0]            o_fill_addr,
   output logic [MW*LINE_WORDS-1:0] o_fill_line,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic [AW-1:0]            o_wb_addr,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_err,
   input  logic [MW-1:0]            i_wb_data
);

   localparam int BW  = MW / 8;
   localparam int OFF = $clog2(LINE_WORDS * BW);
   localparam int IW  = $clog2(LINE_WORDS);
   localparam int CW  = IW + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
   localparam logic [7:0]    TIMER_MAX = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           fill_addr_q, fill_addr_d;
   logic [AW-1:0]           wb_addr_q, wb_addr_d;
   logic                    cyc_q, cyc_d;
   logic                    stb_q, stb_d;
   logic                    err_q, err_d;
   logic [CW-1:0]           issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]           ack_cnt_q, ack_cnt_d;
   logic [7:0]              timer_q, timer_d;
   logic [MW*LINE_WORDS-1:0] line_q, line_d;
   logic [AW-1:0]           base;
   logic                    issue;

   assign base = {i_miss_addr[AW-1:OFF], {OFF{1'b0}}};

   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      wb_addr_d   = wb_addr_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      err_d       = err_q;
      issue_cnt_d = issue_cnt_q;
      ack_cnt_d   = ack_cnt_q;
      timer_d     = timer_q;
      line_d      = line_q;
      issue       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_miss_req) begin
               state_d     = S_BUS;
               fill_addr_d = base;
               wb_addr_d   = base;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               err_d       = 1'b0;
               issue_cnt_d = '0;
               ack_cnt_d   = '0;
               timer_d     = '0;
            end
         end

         S_BUS: begin
            issue = stb_q & ~i_wb_stall;
            if (issue) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               wb_addr_d   = wb_addr_q + AW'(BW);
               if (issue_cnt_q == LAST_BEAT) begin
                  stb_d = 1'b0;
               end
            end

            // An error outranks a coincident ack; the partially filled line is left as is.
            if (i_wb_err || (timer_q == TIMER_MAX)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
            end else if (i_wb_ack) begin
               line_d[int'(ack_cnt_q[IW-1:0]) * MW +: MW] = i_wb_data;
               ack_cnt_d = ack_cnt_q + 1'b1;
               timer_d   = '0;
               if (ack_cnt_q == LAST_BEAT) begin
                  state_d = S_DONE;
                  err_d   = 1'b0;
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         fill_addr_q <= '0;
         wb_addr_q   <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         err_q       <= 1'b0;
         issue_cnt_q <= '0;
         ack_cnt_q   <= '0;
         timer_q     <= '0;
         line_q      <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         wb_addr_q   <= wb_addr_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         err_q       <= err_d;
         issue_cnt_q <= issue_cnt_d;
         ack_cnt_q   <= ack_cnt_d;
         timer_q     <= timer_d;
         line_q      <= line_d;
      end
   end

   assign o_busy      = (state_q != S_IDLE);
   assign o_fill_done = (state_q == S_DONE);
   assign o_fill_err  = (state_q == S_DONE) & err_q;
   assign o_fill_addr = fill_addr_q;
   assign o_fill_line = line_q;
   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_addr   = wb_addr_q;

endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill: table of clean refills with stalls, then
// hand-written error, timeout, reset and held-request sequences.
module tb_icache_line_refill;

   localparam int AW = 32;
   localparam int MW = 64;
   localparam int LW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              miss_req;
   logic [AW-1:0]     miss_addr;
   logic              busy;
   logic              fill_done;
   logic              fill_err;
   logic [AW-1:0]     fill_addr;
   logic [MW*LW-1:0]  fill_line;
   logic              wb_cyc;
   logic              wb_stb;
   logic [AW-1:0]     wb_addr;
   logic              wb_stall;
   logic              wb_ack;
   logic              wb_err;
   logic [MW-1:0]     wb_data;

   int errors = 0;
   int checks = 0;

   logic              ack_enable;
   logic              pend_acc;
   logic [AW-1:0]     pend_addr;
   logic [AW-1:0]     accept_addr[$];

   always #5 clk = ~clk;

   icache_line_refill #(
      .AW(AW), .MW(MW), .LINE_WORDS(LW), .TIMEOUT(255)
   ) dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_miss_req(miss_req),
      .i_miss_addr(miss_addr),
      .o_busy(busy),
      .o_fill_done(fill_done),
      .o_fill_err(fill_err),
      .o_fill_addr(fill_addr),
      .o_fill_line(fill_line),
      .o_wb_cyc(wb_cyc),
      .o_wb_stb(wb_stb),
      .o_wb_addr(wb_addr),
      .i_wb_stall(wb_stall),
      .i_wb_ack(wb_ack),
      .i_wb_err(wb_err),
      .i_wb_data(wb_data)
   );

   function automatic logic [MW-1:0] dataFor(input logic [AW-1:0] a);
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   function automatic logic [MW*LW-1:0] lineFor(input logic [AW-1:0] b);
      logic [MW*LW-1:0] l;
      l = '0;
      for (int k = 0; k < LW; k++) l[k*MW +: MW] = dataFor(b + AW'(8 * k));
      return l;
   endfunction

   // Slave model: a strobe accepted in one cycle is acked with address-derived data the next.
   initial begin
      wb_ack  = 1'b0;
      wb_data = '0;
      forever begin
         @(negedge clk);
         pend_acc  = (wb_cyc === 1'b1) && (wb_stb === 1'b1) && (wb_stall === 1'b0);
         pend_addr = wb_addr;
         if (pend_acc) accept_addr.push_back(wb_addr);
         @(posedge clk);
         #1;
         wb_ack  = pend_acc && ack_enable;
         wb_data = dataFor(pend_addr);
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic req, input logic [AW-1:0] addr);
      miss_req  = req;
      miss_addr = addr;
   endtask

   task automatic checkOutput(input string name, input logic [MW*LW-1:0] act,
                              input logic [MW*LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 50) begin
         nextCycle();
         n++;
      end
      checkOutput("waitIdle", busy, 0);
   endtask

   // Issues one request in the current cycle and runs until the done pulse (cycle index relative to request).
   task automatic runRefill(input logic [AW-1:0] addr, input int stall_len,
                            input logic [AW-1:0] exp_base,
                            output int done_rel, output int addr2_cycles);
      int stall_cnt;
      stall_cnt    = 0;
      done_rel     = -1;
      addr2_cycles = 0;
      accept_addr.delete();
      applyStimulus(1'b1, addr);
      for (int t = 1; t <= 400 && done_rel < 0; t++) begin
         nextCycle();
         if (t == 1) applyStimulus(1'b0, addr);
         if (accept_addr.size() == 2 && stall_cnt < stall_len) begin
            wb_stall = 1'b1;
            stall_cnt++;
         end else begin
            wb_stall = 1'b0;
         end
         if (wb_stb === 1'b1 && wb_addr === exp_base + 32'd16) addr2_cycles++;
         if (fill_done === 1'b1) done_rel = t;
      end
      wb_stall = 1'b0;
   endtask

   typedef struct {
      logic [AW-1:0] miss_addr;
      int            stall_len;
      logic [AW-1:0] exp_base;
      int            exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int done_rel;
      int addr2;
      int rises;
      int dones;
      logic prev_busy;

      vecs[0] = '{32'h0000_1234, 0, 32'h0000_1220, 6};
      vecs[1] = '{32'h0000_1234, 3, 32'h0000_1220, 9};
      vecs[2] = '{32'hFFFF_FFE7, 0, 32'hFFFF_FFE0, 6};
      vecs[3] = '{32'h8000_0000, 1, 32'h8000_0000, 7};
      vecs[4] = '{32'h0000_003F, 2, 32'h0000_0020, 8};

      reset      = 1'b1;
      ack_enable = 1'b1;
      wb_stall   = 1'b0;
      wb_err     = 1'b0;
      applyStimulus(1'b0, '0);
      nextCycle();
      nextCycle();
      reset = 1'b0;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", fill_done, 0);
      checkOutput("rstErr", fill_err, 0);
      checkOutput("rstCyc", wb_cyc, 0);
      checkOutput("rstStb", wb_stb, 0);
      checkOutput("rstFillAddr", fill_addr, 0);
      checkOutput("rstWbAddr", wb_addr, 0);
      checkOutput("rstLine", fill_line, 0);

      for (int i = 0; i < 5; i++) begin
         runRefill(vecs[i].miss_addr, vecs[i].stall_len, vecs[i].exp_base, done_rel, addr2);
         checkOutput("doneCycle", done_rel, vecs[i].exp_done);
         checkOutput("fillErr", fill_err, 0);
         checkOutput("fillAddr", fill_addr, vecs[i].exp_base);
         checkOutput("fillLine", fill_line, lineFor(vecs[i].exp_base));
         checkOutput("acceptCount", accept_addr.size(), LW);
         for (int k = 0; k < accept_addr.size(); k++)
            checkOutput("beatAddr", accept_addr[k], vecs[i].exp_base + AW'(8 * k));
         checkOutput("beat2Hold", addr2, vecs[i].stall_len + 1);
         nextCycle();
         checkOutput("doneWidth", fill_done, 0);
         checkOutput("busyAfterDone", busy, 0);
      end

      // Bus error together with the second ack.
      accept_addr.delete();
      applyStimulus(1'b1, 32'h0000_4004);
      nextCycle();
      applyStimulus(1'b0, '0);
      checkOutput("errFirstStb", wb_addr, 32'h0000_4000);
      nextCycle();
      nextCycle();
      wb_err = 1'b1;
      nextCycle();
      wb_err = 1'b0;
      checkOutput("errDone", fill_done, 1);
      checkOutput("errFlag", fill_err, 1);
      checkOutput("errCyc", wb_cyc, 0);
      checkOutput("errStb", wb_stb, 0);
      checkOutput("errBeat0", fill_line[63:0], dataFor(32'h0000_4000));
      checkOutput("errBeat1Kept", fill_line[127:64], dataFor(32'h0000_0028));
      nextCycle();
      checkOutput("errBeat2Kept", fill_line[191:128], dataFor(32'h0000_0030));
      checkOutput("errDoneOnce", fill_done, 0);
      checkOutput("errIdle", busy, 0);
      applyStimulus(1'b1, 32'h0000_5008);
      nextCycle();
      applyStimulus(1'b0, '0);
      checkOutput("reqAfterErr", busy, 1);
      checkOutput("reqAfterErrAddr", wb_addr, 32'h0000_5000);
      waitIdle();

      // Slave never acks: timeout abort.
      ack_enable = 1'b0;
      accept_addr.delete();
      done_rel = -1;
      applyStimulus(1'b1, 32'h0000_8010);
      for (int t = 1; t <= 400 && done_rel < 0; t++) begin
         nextCycle();
         if (t == 1) applyStimulus(1'b0, '0);
         if (fill_done === 1'b1) done_rel = t;
      end
      checkOutput("toDoneCycle", done_rel, 257);
      checkOutput("toErr", fill_err, 1);
      checkOutput("toAccepts", accept_addr.size(), LW);
      nextCycle();
      checkOutput("toBusyFall", busy, 0);
      ack_enable = 1'b1;

      // Reset while beat 2 is on the bus.
      accept_addr.delete();
      applyStimulus(1'b1, 32'h0000_9000);
      nextCycle();
      applyStimulus(1'b0, '0);
      nextCycle();
      nextCycle();
      checkOutput("rmBeat2Addr", wb_addr, 32'h0000_9010);
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      checkOutput("rmBusy", busy, 0);
      checkOutput("rmCyc", wb_cyc, 0);
      checkOutput("rmStb", wb_stb, 0);
      checkOutput("rmDone", fill_done, 0);
      checkOutput("rmLine", fill_line, 0);
      dones = 0;
      for (int t = 0; t < 6; t++) begin
         nextCycle();
         if (fill_done === 1'b1) dones++;
      end
      checkOutput("rmNoDone", dones, 0);

      // Request held high through several refills.
      accept_addr.delete();
      prev_busy = busy;
      rises = 0;
      dones = 0;
      applyStimulus(1'b1, 32'h0000_A000);
      for (int t = 1; t <= 28; t++) begin
         nextCycle();
         if (busy === 1'b1 && prev_busy === 1'b0) rises++;
         if (fill_done === 1'b1) dones++;
         prev_busy = busy;
      end
      applyStimulus(1'b0, '0);
      checkOutput("holdAccepts", rises, 4);
      checkOutput("holdDones", dones, 4);
      checkOutput("holdBeats", accept_addr.size(), 4 * LW);
      waitIdle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
